debounce_bank: RTL and testbench

//   Multi-bit switch debouncer feeding the 4-bit adder/display datapath.

---
 rtl/debounce_bank_if.sv | 22 ++
 rtl/debounce_bank.sv | 164 ++++++++++++++++
 tb/tb_debounce_bank.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bank_if
// Description : Switch/debounce bundle between the raw switch source and the
//               debounce bank. The master drives the raw switches and
//               observes the debounced results; the slave is the bank.
//   sw        master->slave  WIDTH  raw, bouncing switch inputs
//   db_level  slave->master  WIDTH  debounced switch levels
//   db_tick   slave->master  WIDTH  one-cycle pulse per accepted rising edge
// Revision    : 1.0  initial release
// ============================================================================
interface debounce_bank_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] sw;
   logic [WIDTH-1:0] db_level;
   logic [WIDTH-1:0] db_tick;

   modport master (output sw, input db_level, input db_tick);
   modport slave  (input sw, output db_level, output db_tick);
endinterface
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bank
// Description : Multi-bit switch debouncer. Every switch bit runs its own
//               four-state FSM (ZERO, WAIT1, ONE, WAIT0); a single shared
//               N-bit counter produces the sample tick that paces them all.
//               A change is accepted only after the input has held for
//               STABLE_TICKS consecutive ticks.
// Ports       :
//   clk            in   1      system clock, rising edge
//   reset          in   1      asynchronous, active-low reset
//   bus.sw         in   WIDTH  raw switch inputs
//   bus.db_level   out  WIDTH  debounced levels (Moore, from FSM state)
//   bus.db_tick    out  WIDTH  registered pulse on each accepted 0->1 edge
// Build option:
//   DEBOUNCE_SYNC_EN  defined  : 2-flop synchronizer per sw bit (+2 cycles)
//                     undefined: sw drives the FSMs directly; sw must
//                                already be synchronous to clk
// Revision    : 1.0  initial release
// ============================================================================
module debounce_bank #(
   parameter int WIDTH        = 4,
   parameter int N            = 19,
   parameter int STABLE_TICKS = 3
) (
   input  wire            clk,
   input  wire            reset,
   debounce_bank_if.slave bus
);

   // A counter of width clog2(1)=0 is not legal, so keep at least one bit.
   localparam int               CNT_W    = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   typedef enum logic [1:0] {
      ST_ZERO  = 2'd0,
      ST_WAIT1 = 2'd1,
      ST_ONE   = 2'd2,
      ST_WAIT0 = 2'd3
   } state_t;

   // -------------------------------------------------------------------------
   // Shared sample-tick counter: m_tick is high one cycle in every 2^N.
   // -------------------------------------------------------------------------
   logic [N-1:0] q_q;
   logic         m_tick;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_q + {{(N-1){1'b0}}, 1'b1};
      end
   end

   assign m_tick = &q_q;

   // -------------------------------------------------------------------------
   // Switch input path
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] sw_s;

`ifdef DEBOUNCE_SYNC_EN
   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= bus.sw;
         sync2_q <= sync1_q;
      end
   end

   assign sw_s = sync2_q;
`else
   assign sw_s = bus.sw;
`endif

   // -------------------------------------------------------------------------
   // Per-bit debounce FSMs
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] level_vec;
   logic [WIDTH-1:0] tick_vec;

   generate
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
         state_t           state_q, state_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             tick_q, tick_d;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               state_q <= ST_ZERO;
               cnt_q   <= '0;
               tick_q  <= 1'b0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
               tick_q  <= tick_d;
            end
         end

         // An input reversal is tested before m_tick so a bounce landing on
         // the final tick cancels the pending change instead of accepting it.
         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            tick_d  = 1'b0;
            case (state_q)
               ST_ZERO: begin
                  if (sw_s[b]) begin
                     state_d = ST_WAIT1;
                     cnt_d   = '0;
                  end
               end
               ST_WAIT1: begin
                  if (!sw_s[b]) begin
                     state_d = ST_ZERO;
                  end else if (m_tick) begin
                     if (cnt_q == CNT_LAST) begin
                        state_d = ST_ONE;
                        tick_d  = 1'b1;   // only a WAIT1->ONE entry pulses
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
               end
               ST_ONE: begin
                  if (!sw_s[b]) begin
                     state_d = ST_WAIT0;
                     cnt_d   = '0;
                  end
               end
               ST_WAIT0: begin
                  if (sw_s[b]) begin
                     state_d = ST_ONE;
                  end else if (m_tick) begin
                     if (cnt_q == CNT_LAST) begin
                        state_d = ST_ZERO;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
               end
               default: begin
                  state_d = ST_ZERO;
                  cnt_d   = '0;
               end
            endcase
         end

         assign level_vec[b] = (state_q == ST_ONE) || (state_q == ST_WAIT0);
         assign tick_vec[b]  = tick_q;
      end
   endgenerate

   assign bus.db_level = level_vec;
   assign bus.db_tick  = tick_vec;

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_bank
// Description : Directed self-checking bench for debounce_bank with WIDTH=4,
//               N=4 (16-cycle tick) and STABLE_TICKS=3. Builds with or
//               without DEBOUNCE_SYNC_EN; the latency window shifts by 2.
//               Latency is counted in clk edges after the first edge that
//               samples the new, stable switch value.
// Revision    : 1.0  initial release
// ============================================================================
module tb_debounce_bank;

   localparam int WIDTH        = 4;
   localparam int N            = 4;
   localparam int STABLE_TICKS = 3;
   localparam int PERIOD       = 1 << N;
`ifdef DEBOUNCE_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif
   localparam int LAT_MIN = (STABLE_TICKS - 1) * PERIOD + 1 + SL;
   localparam int LAT_MAX = STABLE_TICKS * PERIOD + SL;
   localparam int TMO     = 200;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int errors = 0;
   int checks = 0;
   int tick_hits [WIDTH];

   debounce_bank_if #(.WIDTH(WIDTH)) bus ();

   debounce_bank #(
      .WIDTH       (WIDTH),
      .N           (N),
      .STABLE_TICKS(STABLE_TICKS)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Counts the cycles each db_tick bit is seen high.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < WIDTH; i++) begin
         if (bus.db_tick[i] === 1'b1) tick_hits[i]++;
      end
   end

   task automatic clear_hits();
      for (int i = 0; i < WIDTH; i++) tick_hits[i] = 0;
   endtask

   // Leaves the caller on the negedge where reset was released.
   task automatic do_reset(input logic [WIDTH-1:0] sw_val);
      @(negedge clk);
      reset  = 1'b0;
      bus.sw = sw_val;
      repeat (3) @(negedge clk);
      clear_hits();
      reset = 1'b1;
   endtask

   task automatic wait_level(input logic [WIDTH-1:0] val, output int edges, output bit found);
      edges = 0;
      found = 1'b0;
      while (!found && edges < TMO) begin
         @(posedge clk);
         #1;
         edges++;
         if (bus.db_level === val) found = 1'b1;
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      int bad;
      bad = 0;
      bus.sw = 4'hF;
      #2 reset = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (bus.db_level !== 4'h0 || bus.db_tick !== 4'h0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_outputs: level=%h tick=%h in %0d cycles, need 0", bus.db_level, bus.db_tick, bad);
      end
      checks++;
      if (dut.q_q !== 4'd0) begin
         errors++;
         $display("FAIL reset_counter: q=%0d, need 0", dut.q_q);
      end
   endtask

   task automatic test_rise();
      int  edges;
      bit  found;
      int  bad;
      @(negedge clk);
      clear_hits();
      reset = 1'b1;
      wait_level(4'hF, edges, found);
      checks++;
      if (!found || edges - 1 < LAT_MIN || edges - 1 > LAT_MAX) begin
         errors++;
         $display("FAIL rise_latency: found=%0d latency=%0d, need %0d..%0d", found, edges - 1, LAT_MIN, LAT_MAX);
      end
      checks++;
      if (bus.db_tick !== 4'hF) begin
         errors++;
         $display("FAIL rise_tick_first: tick=%h, need f", bus.db_tick);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.db_tick !== 4'h0) begin
         errors++;
         $display("FAIL rise_tick_second: tick=%h, need 0", bus.db_tick);
      end
      repeat (10) @(posedge clk);
      #1;
      bad = 0;
      for (int i = 0; i < WIDTH; i++) if (tick_hits[i] != 1) bad++;
      checks++;
      if (bad != 0 || bus.db_level !== 4'hF) begin
         errors++;
         $display("FAIL rise_tick_count: %0d bits without exactly one pulse, level=%h, need 0 and f", bad, bus.db_level);
      end
   endtask

   task automatic test_bounce();
      int viol;
      viol = 0;
      do_reset(4'b0100);
      for (int i = 0; i < 200; i++) begin
         bus.sw[0] = (((i / 5) % 2) == 0) ? 1'b1 : 1'b0;
         @(posedge clk);
         #1;
         if (bus.db_level[0] !== 1'b0 || bus.db_tick[0] !== 1'b0) viol++;
         @(negedge clk);
      end
      bus.sw[0] = 1'b0;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (bus.db_level[0] !== 1'b0 || bus.db_tick[0] !== 1'b0) viol++;
      end
      checks++;
      if (viol != 0 || tick_hits[0] != 0) begin
         errors++;
         $display("FAIL bounce_bit0: %0d bad cycles, %0d pulses, need 0 and 0", viol, tick_hits[0]);
      end
      checks++;
      if (bus.db_level !== 4'b0100 || tick_hits[2] != 1) begin
         errors++;
         $display("FAIL bounce_independent: level=%b pulses2=%0d, need 0100 and 1", bus.db_level, tick_hits[2]);
      end
   endtask

   task automatic test_fall_glitch();
      int edges;
      bit found;
      int hits;
      do_reset(4'hF);
      wait_level(4'hF, edges, found);
      @(negedge clk);
      clear_hits();
      bus.sw = 4'h0;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (!found || bus.db_level !== 4'hF) begin
         errors++;
         $display("FAIL fall_wait0_level: found=%0d level=%h, need 1 and f", found, bus.db_level);
      end
      @(negedge clk);
      bus.sw = 4'hF;
      repeat (2) @(negedge clk);
      bus.sw = 4'h0;
      wait_level(4'h0, edges, found);
      checks++;
      if (!found || edges - 1 < LAT_MIN || edges - 1 > LAT_MAX) begin
         errors++;
         $display("FAIL fall_latency: found=%0d latency=%0d, need %0d..%0d", found, edges - 1, LAT_MIN, LAT_MAX);
      end
      repeat (5) @(posedge clk);
      #1;
      hits = 0;
      for (int i = 0; i < WIDTH; i++) hits += tick_hits[i];
      checks++;
      if (hits != 0) begin
         errors++;
         $display("FAIL fall_no_tick: %0d pulses seen, need 0", hits);
      end
   endtask

   task automatic test_simul();
      int edges;
      bit found;
      int bad;
      do_reset(4'b0010);
      // Edges 16 and 32 advance cnt to 2; edge 48 carries the final tick.
      // The drop is timed so the FSM sees sw=0 at exactly that edge.
      repeat (47 - SL) @(posedge clk);
      @(negedge clk);
      bus.sw = 4'b0000;
      repeat (SL + 1) @(posedge clk);
      #1;
      checks++;
      if (bus.db_level[1] !== 1'b0 || bus.db_tick[1] !== 1'b0) begin
         errors++;
         $display("FAIL simul_reversal: level1=%b tick1=%b, need 0 and 0", bus.db_level[1], bus.db_tick[1]);
      end
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (bus.db_level !== 4'b0000 || tick_hits[1] != 0) begin
         errors++;
         $display("FAIL simul_stays_zero: level=%b pulses1=%0d, need 0000 and 0", bus.db_level, tick_hits[1]);
      end
      @(negedge clk);
      clear_hits();
      bus.sw = 4'b0101;
      wait_level(4'b0101, edges, found);
      checks++;
      if (!found || bus.db_tick !== 4'b0101) begin
         errors++;
         $display("FAIL simul_pair_rise: found=%0d tick=%b, need 1 and 0101", found, bus.db_tick);
      end
      repeat (5) @(posedge clk);
      #1;
      bad = 0;
      for (int i = 0; i < WIDTH; i++) if (tick_hits[i] != ((i % 2 == 0) ? 1 : 0)) bad++;
      checks++;
      if (bad != 0 || bus.db_level !== 4'b0101) begin
         errors++;
         $display("FAIL simul_pair_pulses: %0d bits wrong, level=%b, need 0 and 0101", bad, bus.db_level);
      end
   endtask

   task automatic test_async_reset();
      int edges;
      bit found;
      do_reset(4'hF);
      wait_level(4'hF, edges, found);
      @(negedge clk);
      bus.sw = 4'h0;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (!found || bus.db_level !== 4'hF) begin
         errors++;
         $display("FAIL async_pre_level: found=%0d level=%h, need 1 and f", found, bus.db_level);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (bus.db_level !== 4'h0 || bus.db_tick !== 4'h0 || dut.q_q !== 4'd0) begin
         errors++;
         $display("FAIL async_immediate: level=%h tick=%h q=%0d, need 0 0 0", bus.db_level, bus.db_tick, dut.q_q);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (dut.q_q !== 4'd0) begin
         errors++;
         $display("FAIL async_q_release: q=%0d, need 0", dut.q_q);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (dut.q_q !== 4'd5 || bus.db_level !== 4'h0) begin
         errors++;
         $display("FAIL async_q_restart: q=%0d level=%h, need 5 and 0", dut.q_q, bus.db_level);
      end
   endtask

   // ------------------------------------------------------------------------
   initial begin
      bus.sw = '0;
      clear_hits();
      test_reset();
      test_rise();
      test_bounce();
      test_fall_glitch();
      test_simul();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not finish, need completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
